seq_controller: RTL and testbench
=================================

SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have no parameters; opcode and phase encodings come from the shared package.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 opcode  in  3  current instruction opcode from instruction register; valid from phase 3 onward.
REQ-005 zero  in  1  accumulator-zero flag.
REQ-006 sel  out  1  memory address mux: 1 = PC address, 0 = operand address.
REQ-007 rd  out  1  memory read enable.
REQ-008 ld_ir  out  1  instruction register load.
REQ-009 inc_pc  out  1  PC advance strobe.
REQ-010 skip  out  1  PC advance by 2 instead of 1; drives the next-address adder skip input.
REQ-011 ld_pc  out  1  PC load from operand field (jump).
REQ-012 ld_ac  out  1  accumulator load.
REQ-013 wr  out  1  memory write enable.
REQ-014 data_e  out  1  accumulator-to-data-bus drive enable.
REQ-015 halt  out  1  processor halted.
REQ-016 phase  out  3  current phase, 0..7, for debug and bench observation.

Function
REQ-017 Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-018 Phase register SHALL advance by 1 every clock, with wrap 7->0 and no idle cycles; each instruction SHALL take exactly 8 clocks.
REQ-019 Outputs SHALL be combinational from the registered phase plus opcode and zero (Moore on phase), with no added register stage.
REQ-020 Phase 0 INST_ADDR: sel=1.
REQ-021 Phase 1 INST_FETCH: sel=1, rd=1.
REQ-022 Phases 2 INST_LOAD and 3 IDLE: sel=1, rd=1, ld_ir=1.
REQ-023 Phase 4 OP_ADDR: inc_pc=1 unless opcode=HLT; halt=1 if opcode=HLT.
REQ-024 Phase 5 OP_FETCH: rd=ALUOP.
REQ-025 Phase 6 ALU_OP: rd=ALUOP; inc_pc=skip=(opcode=SKZ & zero); ld_pc=JMP; data_e=STO.
REQ-026 Phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
REQ-027 All outputs not listed for a phase SHALL be 0.
REQ-028 HLT: on reaching phase 4 with opcode=HLT, the phase register SHALL freeze at 4; halt SHALL hold at 1; all other outputs SHALL be 0.
REQ-029 wr and rd SHALL never be 1 in the same cycle; ld_pc and inc_pc SHALL never be 1 in the same cycle.
REQ-030 zero SHALL be sampled only in phase 6; zero changes in other phases SHALL have no effect.

Reset
REQ-031 rst=0 SHALL force phase=0 immediately, independent of clk, and SHALL clear the halted state.
REQ-032 During reset, outputs SHALL be sel=1 and all others 0; the first rising edge after rst deasserts SHALL move the phase to 1.
REQ-033 Reset asserted mid-instruction (any phase, including halted) SHALL abandon the instruction with no partial wr, ld_ac or ld_pc.

Configuration
REQ-034 Macro SEQ_CTRL_RESUME_EN, when defined, SHALL add input resume (1 bit).
- While halted, resume=1 at a rising edge SHALL clear halt and set the phase to 5; inc_pc=1 SHALL be asserted for that one cycle so execution continues past the HLT.
- When the macro is undefined, the port SHALL be absent and the halted state SHALL be left only by reset.

Structure
REQ-035 Package seq_ctrl_pkg SHALL hold the opcode constants, the phase constants (INST_ADDR..STORE) and the ALUOP decode function.
REQ-036 Sub-module seq_phase_counter SHALL implement the 3-bit wrapping counter with hold enable and async active-low clear; seq_controller SHALL instantiate it and own the decode logic.

Verification
REQ-037 Release reset with opcode=ADD -> phases 0..7 in order; ld_ir high in phases 2-3; inc_pc in phase 4; rd in 5-7; ld_ac only in phase 7.
REQ-038 opcode=SKZ: zero=1 -> inc_pc and skip high in phase 6; zero=0 -> both low in phase 6; inc_pc in phase 4 in both cases.
REQ-039 opcode=STO -> data_e in phases 6-7, wr only in phase 7, rd low in phases 5-7.
REQ-040 opcode=JMP -> ld_pc in phases 6-7, inc_pc only in phase 4; opcode=HLT -> phase stuck at 4 and halt=1 for 20 clocks.
REQ-041 rst pulsed low mid-phase 6 during STO -> phase=0 at once; wr never asserted; sel=1.
REQ-042 With SEQ_CTRL_RESUME_EN defined: halted, then resume=1 for 1 clock -> halt=0, inc_pc=1 for that cycle, phase=5 next.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the sequence controller: opcodes, phase names and
// the ALU-class opcode decode.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // True for opcodes that read an operand and load the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        logic result;
        case (op)
            ADD, AND, XOR, LDA: result = 1'b1;
            default:            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// 3-bit wrapping phase counter. Advances every clock unless hold is high;
// rst (active-low) clears it asynchronously.
module seq_phase_counter
    import seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [2:0] phase
);

    logic [2:0] phase_r;

    // Phase register: async clear, otherwise hold or advance with 7->0 wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= 3'd0;
        end else if (hold) begin
            phase_r <= phase_r;
        end else begin
            phase_r <= phase_r + 3'd1;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer. Control strobes are decoded directly
// from the registered phase plus the current opcode and zero flag.
// Optional feature macro: SEQ_CTRL_RESUME_EN adds a resume input that
// restarts execution from a halt at phase 5 with one PC advance.
module seq_controller
    import seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef SEQ_CTRL_RESUME_EN
    input  logic       resume,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       skip,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    logic [2:0] phase_s;
    logic       resume_s;
    logic       is_hlt_s;
    logic       is_alu_s;
    logic       is_sto_s;
    logic       is_jmp_s;
    logic       skz_taken_s;
    logic       hold_s;

`ifdef SEQ_CTRL_RESUME_EN
    assign resume_s = resume;
`else
    assign resume_s = 1'b0;
`endif

    assign is_hlt_s    = (opcode == HLT);
    assign is_alu_s    = is_aluop(opcode);
    assign is_sto_s    = (opcode == STO);
    assign is_jmp_s    = (opcode == JMP);
    // zero only matters in the ALU_OP phase, where it is consumed here.
    assign skz_taken_s = (opcode == SKZ) && zero;

    // A halt freezes the counter at OP_ADDR until reset (or resume).
    assign hold_s = (phase_s == OP_ADDR) && is_hlt_s && !resume_s;

    seq_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold_s),
        .phase (phase_s)
    );

    // Moore-on-phase decode of all control strobes.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        skip   = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (phase_s)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                if (is_hlt_s) begin
                    // Resuming steps the PC past the HLT instead of halting.
                    inc_pc = resume_s;
                    halt   = !resume_s;
                end else begin
                    inc_pc = 1'b1;
                    halt   = 1'b0;
                end
            end
            OP_FETCH: begin
                rd = is_alu_s;
            end
            ALU_OP: begin
                rd     = is_alu_s;
                inc_pc = skz_taken_s;
                skip   = skz_taken_s;
                ld_pc  = is_jmp_s;
                data_e = is_sto_s;
            end
            STORE: begin
                rd     = is_alu_s;
                ld_ac  = is_alu_s;
                ld_pc  = is_jmp_s;
                wr     = is_sto_s;
                data_e = is_sto_s;
            end
            default: begin
                sel = 1'b1;
            end
        endcase
    end

    assign phase = phase_s;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed instruction sequences
// plus randomized opcode/zero traffic, compared each cycle against a
// rule-based reference model.
module tb_seq_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       sel, rd, ld_ir, inc_pc, skip, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int tests_run;
    int tests_failed;
    int exp_phase;

    seq_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef SEQ_CTRL_RESUME_EN
        .resume (resume),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .skip   (skip),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes {sel,rd,ld_ir,inc_pc,skip,ld_pc,ld_ac,wr,data_e,halt}
    // derived from the phase rules with plain arithmetic.
    function automatic logic [9:0] model(input int p, input int op, input bit z, input bit res);
        bit alu, e_sel, e_rd, e_ldir, e_inc, e_skip, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        alu    = (op >= 2) && (op <= 5);
        e_sel  = (p <= 3);
        e_rd   = ((p >= 1) && (p <= 3)) || ((p >= 5) && alu);
        e_ldir = (p == 2) || (p == 3);
        e_skip = (p == 6) && (op == 1) && z;
        e_inc  = ((p == 4) && ((op != 0) || res)) || e_skip;
        e_ldpc = (p >= 6) && (op == 7);
        e_ldac = (p == 7) && alu;
        e_wr   = (p == 7) && (op == 6);
        e_de   = (p >= 6) && (op == 6);
        e_halt = (p == 4) && (op == 0) && !res;
        return {e_sel, e_rd, e_ldir, e_inc, e_skip, e_ldpc, e_ldac, e_wr, e_de, e_halt};
    endfunction

    task automatic check(input string tag);
        logic [9:0] obs_v;
        logic [9:0] exp_v;
        logic [2:0] exp_p;
        #1;
        exp_p = 3'(exp_phase);
        exp_v = model(exp_phase, int'(opcode), zero, resume);
        obs_v = {sel, rd, ld_ir, inc_pc, skip, ld_pc, ld_ac, wr, data_e, halt};
        tests_run++;
        assert (phase === exp_p) else begin
            tests_failed++;
            $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, exp_p);
        end
        tests_run++;
        assert (obs_v === exp_v) else begin
            tests_failed++;
            $error("FAIL %s strobes(phase %0d op %0d) observed=%b expected=%b", tag, exp_phase, opcode, obs_v, exp_v);
        end
        tests_run++;
        assert (!(wr && rd) && !(ld_pc && inc_pc)) else begin
            tests_failed++;
            $error("FAIL %s exclusivity observed wr=%b rd=%b ld_pc=%b inc_pc=%b expected no overlap", tag, wr, rd, ld_pc, inc_pc);
        end
    endtask

    // Advance one clock and update the reference phase from the inputs
    // that were stable at that edge.
    task automatic tick();
        bit frozen;
        frozen = (exp_phase == 4) && (opcode == 3'd0) && !resume;
        @(posedge clk);
        #1;
        if (!rst)        exp_phase = 0;
        else if (!frozen) exp_phase = (exp_phase + 1) % 8;
    endtask

    // One full instruction from phase 0; zmode 0/1 fixes zero at phase 6,
    // 2 randomizes it. zero is randomized in every other phase.
    task automatic run_instr(input logic [2:0] op, input int zmode, input string tag);
        opcode = op;
        for (int k = 0; k < 8; k++) begin
            if (exp_phase == 6 && zmode < 2) zero = (zmode == 1);
            else                             zero = 1'($urandom_range(0, 1));
            check(tag);
            tick();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_phase    = 0;
        rst          = 1'b0;
        opcode       = 3'd2;
        zero         = 1'b0;
        resume       = 1'b0;

        // Reset state, including across clock edges while held.
        check("reset");
        tick();
        check("reset_held");
        tick();
        check("reset_held2");

        // Release reset between edges; first edge moves phase to 1.
        rst = 1'b1;
        check("reset_release");
        tick();
        check("first_edge");
        for (int k = 1; k < 8; k++) begin
            check("add_tail");
            tick();
        end

        // Directed instruction classes.
        run_instr(3'd2, 2, "add");
        run_instr(3'd1, 1, "skz_zero1");
        run_instr(3'd1, 0, "skz_zero0");
        run_instr(3'd6, 2, "sto");
        run_instr(3'd7, 2, "jmp");
        run_instr(3'd3, 2, "and");
        run_instr(3'd4, 2, "xor");
        run_instr(3'd5, 2, "lda");

        // Randomized non-halting instruction stream.
        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom_range(1, 7)), 2, "rand");
        end

        // Reset pulsed mid-phase 6 of a STO: immediate phase 0, no write.
        opcode = 3'd6;
        while (exp_phase != 6) begin
            check("sto_pre_rst");
            tick();
        end
        check("sto_phase6");
        #2;
        rst = 1'b0;
        exp_phase = 0;
        check("rst_mid_sto");
        tick();
        check("rst_mid_sto_held");
        rst = 1'b1;
        check("rst_mid_sto_release");
        tick();
        for (int k = 1; k < 8; k++) begin
            check("post_rst");
            tick();
        end

        // HLT: freeze at phase 4 with halt high for 20 clocks.
        opcode = 3'd0;
        for (int k = 0; k < 4; k++) begin
            check("hlt_pre");
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            zero = 1'($urandom_range(0, 1));
            check("hlt_frozen");
            tick();
        end
        check("hlt_frozen_end");

`ifdef SEQ_CTRL_RESUME_EN
        // Resume for one clock: inc_pc in that cycle, phase 5 next.
        resume = 1'b1;
        check("resume_cycle");
        tick();
        resume = 1'b0;
        check("resume_phase5");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("resume_tail");
        end
`else
        // Without resume only reset leaves the halted state.
        rst = 1'b0;
        exp_phase = 0;
        check("hlt_reset");
        rst = 1'b1;
        tick();
        check("hlt_after_reset");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout reached observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
